// File: rtl/call_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : call_frame_ctrl_pkg
//  Description : Shared encodings for the call-frame controller: SuperStack
//                op/status codes, execution-unit command codes and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package call_frame_ctrl_pkg;

    // SuperStack op codes (only the subset this controller ever issues)
    localparam logic [2:0] OP_NONE      = 3'd0;
    localparam logic [2:0] OP_PUSH      = 3'd1;
    localparam logic [2:0] OP_POP       = 3'd2;

    // SuperStack status codes
    localparam logic [2:0] ST_NONE      = 3'd0;
    localparam logic [2:0] ST_EMPTY     = 3'd1;
    localparam logic [2:0] ST_FULL      = 3'd2;
    localparam logic [2:0] ST_OVERFLOW  = 3'd3;
    localparam logic [2:0] ST_UNDERFLOW = 3'd4;

    // Execution-unit command codes; 0 and 3 are no-ops
    localparam logic [1:0] CMD_CALL     = 2'd1;
    localparam logic [1:0] CMD_RETURN   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_C_ADDR   = 4'd1,
        S_C_ADDR_W = 4'd2,
        S_C_BASE   = 4'd3,
        S_C_BASE_W = 4'd4,
        S_C_UNDO   = 4'd5,
        S_R_POP1   = 4'd6,
        S_R_POP2   = 4'd7,
        S_DONE     = 4'd8,
        S_ERR      = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/call_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : call_frame_ctrl
//  Description : Drives a SuperStack used as the call stack. A CALL pushes the
//                return address then the caller's frame base; a RETURN pops
//                both back. frame_base bounds the callee's data-stack access.
//  Ports       : clk/reset          - clock, async active-high reset
//                cmd_*              - command handshake from execution unit
//                data_index         - current data-stack index
//                rsp_*              - completion pulse, popped address, status
//                frame_base         - current frame base
//                stk_op/stk_data    - registered SuperStack op and push data
//                stk_index/out/status - SuperStack feedback
//  Revision    : 1.0 - initial release
// ============================================================================
module call_frame_ctrl
    import call_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] cmd_addr,
    input  logic [DEPTH:0]   cmd_args,
    input  logic [DEPTH:0]   data_index,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_addr,
    output logic [2:0]       rsp_error,
    output logic [DEPTH:0]   frame_base,
    output logic [2:0]       stk_op,
    output logic [WIDTH-1:0] stk_data,
    input  logic [DEPTH:0]   stk_index,
    input  logic [WIDTH-1:0] stk_out,
    input  logic [2:0]       stk_status
);

    // A frame occupies two call-stack entries (address + saved base)
    localparam logic [DEPTH:0] FRAME_ENTRIES = (DEPTH+1)'(2);

    state_t           state_q;
    logic [DEPTH:0]   frame_base_q;
    logic [DEPTH:0]   new_base_q;
    logic [DEPTH:0]   saved_base_q;
    logic [2:0]       stk_op_q;
    logic [WIDTH-1:0] stk_data_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_addr_q;
    logic [2:0]       rsp_error_q;

    assign cmd_ready  = (state_q == S_IDLE) && !reset;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_error  = rsp_error_q;
    assign frame_base = frame_base_q;
    assign stk_op     = stk_op_q;
    assign stk_data   = stk_data_q;

    // All outputs are registered: each state's op/response is loaded on the
    // edge that enters it, so stk_op never sees cmd_* combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            frame_base_q <= '0;
            new_base_q   <= '0;
            saved_base_q <= '0;
            stk_op_q     <= OP_NONE;
            stk_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_error_q  <= ST_NONE;
        end else begin
            rsp_valid_q <= 1'b0;
            stk_op_q    <= OP_NONE;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        case (cmd)
                            CMD_CALL: begin
                                if (cmd_args > data_index) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_error_q <= ST_UNDERFLOW;
                                    state_q     <= S_ERR;
                                end else begin
                                    new_base_q <= data_index - cmd_args;
                                    stk_op_q   <= OP_PUSH;
                                    stk_data_q <= cmd_addr;
                                    state_q    <= S_C_ADDR;
                                end
                            end
                            CMD_RETURN: begin
                                if (stk_index < FRAME_ENTRIES) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_error_q <= ST_UNDERFLOW;
                                    state_q     <= S_ERR;
                                end else begin
                                    stk_op_q <= OP_POP;
                                    state_q  <= S_R_POP1;
                                end
                            end
                            default: ; // no-op codes: accepted, no response
                        endcase
                    end
                end
                S_C_ADDR: state_q <= S_C_ADDR_W;
                S_C_ADDR_W: begin
                    // Status now reflects the address push
                    if (stk_status == ST_OVERFLOW) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= ST_OVERFLOW;
                        state_q     <= S_ERR;
                    end else begin
                        stk_op_q   <= OP_PUSH;
                        stk_data_q <= WIDTH'(frame_base_q);
                        state_q    <= S_C_BASE;
                    end
                end
                S_C_BASE: state_q <= S_C_BASE_W;
                S_C_BASE_W: begin
                    if (stk_status == ST_OVERFLOW) begin
                        // Remove the address so the stack matches pre-CALL
                        stk_op_q <= OP_POP;
                        state_q  <= S_C_UNDO;
                    end else begin
                        frame_base_q <= new_base_q;
                        rsp_valid_q  <= 1'b1;
                        rsp_error_q  <= ST_NONE;
                        state_q      <= S_DONE;
                    end
                end
                S_C_UNDO: begin
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= ST_OVERFLOW;
                    state_q     <= S_ERR;
                end
                S_R_POP1: begin
                    // First pop not yet applied: top is the saved base
                    saved_base_q <= stk_out[DEPTH:0];
                    stk_op_q     <= OP_POP;
                    state_q      <= S_R_POP2;
                end
                S_R_POP2: begin
                    // Base popped: top is now the return address
                    frame_base_q <= saved_base_q;
                    rsp_addr_q   <= stk_out;
                    rsp_valid_q  <= 1'b1;
                    rsp_error_q  <= ST_NONE;
                    state_q      <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
